// File: rtl/adc_tx_pkg.sv
// Shared definitions for the ADC byte serialiser: state encoding,
// frame geometry, counter width and the default bit period.
package adc_tx_pkg;

    // 50 MHz clock / 115200 baud
    localparam int CLKS_PER_BIT_DEF = 434;

    // start + 8 data + stop
    localparam int FRAME_BITS = 10;

    // Wide enough for bit periods up to 65535 clocks
    localparam int CNT_W = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_DATA  = 2'd2;
    localparam state_t ST_STOP  = 2'd3;

    // The ADC presents its bits active-low; optionally restore sense.
    function automatic logic [7:0] prep_byte(
        input logic [7:0] b,
        input bit         inv
    );
        return inv ? ~b : b;
    endfunction

endpackage

// File: rtl/adc_byte_tx_if.sv
// Valid/ready byte handshake into the serialiser.
// Ports: tx_data[7:0], tx_valid (producer -> tx), tx_ready (tx -> producer).
interface adc_byte_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/tx_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps.
// Ports: clk, rst (sync, active-high), clear; tick at the last count,
// pre_tick one count earlier so downstream outputs can be registered.
module tx_baud_counter
    import adc_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick     = (count_q == LAST);
    assign pre_tick = (count_q == PRE);

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/adc_byte_tx.sv
// ADC sample byte to 8N1 serial line transmitter.
// Ports: clk, rst (sync, active-high), bus (valid/ready byte in),
// tx (serial out, idle high), busy (frame active), done (end pulse).
module adc_byte_tx
    import adc_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter bit INVERT_DATA  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    adc_byte_tx_if.slave bus,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] idx_q, idx_d;
    logic       tx_q, tx_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic bit_tick;
    logic bit_pre_tick;
    logic cnt_clear;

    tx_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .tick     (bit_tick),
        .pre_tick (bit_pre_tick)
    );

    assign bus.tx_ready = ready_q;
    assign tx           = tx_q;
    assign busy         = busy_q;
    assign done         = done_q;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_clear = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Holding the counter at zero while idle means the
                // start bit gets a full period from acceptance.
                cnt_clear = 1'b1;
                ready_d   = 1'b1;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
                if (ready_q && bus.tx_valid) begin
                    shreg_d = prep_byte(bus.tx_data, INVERT_DATA);
                    idx_d   = 3'd0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    tx_d    = shreg_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end
            end
            ST_STOP: begin
                // Registered done lands in the last stop-bit cycle.
                done_d = bit_pre_tick;
                if (bit_tick) begin
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_adc_byte_tx.sv
// Directed bench for adc_byte_tx with a 4-clock bit period.
// Two instances: plain data sense and inverted data sense.
module tb_adc_byte_tx;
    import adc_tx_pkg::*;

    localparam int CPB = 4;
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    adc_byte_tx_if bus0 ();
    adc_byte_tx_if bus1 ();

    logic tx0, busy0, done0;
    logic tx1, busy1, done1;

    adc_byte_tx #(
        .CLKS_PER_BIT (CPB),
        .INVERT_DATA  (1'b0)
    ) u_dut0 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus0.slave),
        .tx   (tx0),
        .busy (busy0),
        .done (done0)
    );

    adc_byte_tx #(
        .CLKS_PER_BIT (CPB),
        .INVERT_DATA  (1'b1)
    ) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus1.slave),
        .tx   (tx1),
        .busy (busy1),
        .done (done1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs,
                       input logic [9:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic g_tx(input int sel);
        return (sel == 1) ? tx1 : tx0;
    endfunction

    function automatic logic g_busy(input int sel);
        return (sel == 1) ? busy1 : busy0;
    endfunction

    function automatic logic g_done(input int sel);
        return (sel == 1) ? done1 : done0;
    endfunction

    function automatic logic g_rdy(input int sel);
        return (sel == 1) ? bus1.tx_ready : bus0.tx_ready;
    endfunction

    task automatic check_idle(input int sel, input string tag);
        chk({tag, "_tx"},   10'(g_tx(sel)),   10'd1);
        chk({tag, "_busy"}, 10'(g_busy(sel)), 10'd0);
        chk({tag, "_done"}, 10'(g_done(sel)), 10'd0);
        chk({tag, "_rdy"},  10'(g_rdy(sel)),  10'd1);
    endtask

    // Entered in cycle 1 after acceptance; leaves in cycle 41.
    // poke > 0 pulses tx_valid with 0xFF on bus0 in that cycle.
    task automatic check_frame(input int sel, input logic [9:0] exp,
                               input string tag, input int poke);
        for (int c = 1; c <= FRAME_CYC; c++) begin
            chk($sformatf("%s_tx_c%0d", tag, c),
                10'(g_tx(sel)), 10'(exp[(c - 1) / CPB]));
            chk($sformatf("%s_busy_c%0d", tag, c),
                10'(g_busy(sel)), 10'd1);
            chk($sformatf("%s_done_c%0d", tag, c),
                10'(g_done(sel)), 10'(c == FRAME_CYC));
            chk($sformatf("%s_rdy_c%0d", tag, c),
                10'(g_rdy(sel)), 10'd0);
            if (poke > 0 && c == poke) begin
                bus0.tx_data  = 8'hFF;
                bus0.tx_valid = 1'b1;
            end else if (poke > 0 && c == poke + 1) begin
                bus0.tx_valid = 1'b0;
            end
            step(1);
        end
    endtask

    initial begin
        bus0.tx_data  = 8'h00;
        bus0.tx_valid = 1'b0;
        bus1.tx_data  = 8'h00;
        bus1.tx_valid = 1'b0;
        rst = 1'b1;
        step(2);

        // Reset state
        chk("rst_tx0",   10'(tx0),           10'd1);
        chk("rst_busy0", 10'(busy0),         10'd0);
        chk("rst_done0", 10'(done0),         10'd0);
        chk("rst_rdy0",  10'(bus0.tx_ready), 10'd0);
        chk("rst_tx1",   10'(tx1),           10'd1);
        chk("rst_rdy1",  10'(bus1.tx_ready), 10'd0);

        rst = 1'b0;
        step(1);
        check_idle(0, "post_rst0");
        check_idle(1, "post_rst1");

        // 0xA5 plain sense; tx_data changes after acceptance
        bus0.tx_data  = 8'hA5;
        bus0.tx_valid = 1'b1;
        step(1);
        bus0.tx_valid = 1'b0;
        bus0.tx_data  = 8'h3C;
        check_frame(0, 10'b1101001010, "a5", 0);
        check_idle(0, "a5_end");

        // 0x00 inverted sense -> all-ones data bits
        bus1.tx_data  = 8'h00;
        bus1.tx_valid = 1'b1;
        step(1);
        bus1.tx_valid = 1'b0;
        check_frame(1, 10'b1111111110, "inv00", 0);
        check_idle(1, "inv00_end");

        // Valid held high: 0x01 then 0x80, one idle cycle between
        bus0.tx_data  = 8'h01;
        bus0.tx_valid = 1'b1;
        step(1);
        bus0.tx_data  = 8'h80;
        check_frame(0, 10'b1000000010, "b01", 0);
        check_idle(0, "b2b_gap");
        step(1);
        bus0.tx_valid = 1'b0;
        check_frame(0, 10'b1100000000, "b80", 0);
        check_idle(0, "b80_end");
        step(1);
        check_idle(0, "b80_after");

        // Reset at cycle 17 of a 0x55 frame
        bus0.tx_data  = 8'h55;
        bus0.tx_valid = 1'b1;
        step(1);
        bus0.tx_valid = 1'b0;
        step(16);
        chk("abort_tx_c17",   10'(tx0),   10'd0);
        chk("abort_busy_c17", 10'(busy0), 10'd1);
        rst = 1'b1;
        step(1);
        chk("abort_tx",   10'(tx0),           10'd1);
        chk("abort_busy", 10'(busy0),         10'd0);
        chk("abort_done", 10'(done0),         10'd0);
        chk("abort_rdy",  10'(bus0.tx_ready), 10'd0);
        rst = 1'b0;
        step(1);
        check_idle(0, "abort_rel");

        // Valid pulse with 0xFF during DATA is ignored
        bus0.tx_data  = 8'h3C;
        bus0.tx_valid = 1'b1;
        step(1);
        bus0.tx_valid = 1'b0;
        check_frame(0, 10'b1001111000, "ign", 10);
        check_idle(0, "ign_end");
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_idle(0, $sformatf("ign_after%0d", i));
        end

        // rst and tx_valid on the same edge
        rst           = 1'b1;
        bus0.tx_data  = 8'h00;
        bus0.tx_valid = 1'b1;
        step(1);
        chk("rv_tx",   10'(tx0),           10'd1);
        chk("rv_busy", 10'(busy0),         10'd0);
        chk("rv_rdy",  10'(bus0.tx_ready), 10'd0);
        rst           = 1'b0;
        bus0.tx_valid = 1'b0;
        step(1);
        check_idle(0, "rv_rel");
        step(2);
        check_idle(0, "rv_after");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_byte_tx.md
ADC_BYTE_TX -- requirements
Module: adc_byte_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter INVERT_DATA, default 1, when 1 complements the accepted byte before serialising, restoring the active-low ADC bit sense.
REQ-003 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port tx_data  input  8  byte to send (a captured ADC sample).
REQ-006 SHALL have port tx_valid  input  1  tx_data is valid this cycle.
REQ-007 SHALL have port tx_ready  output  1  block can accept a byte this cycle.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  frame in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at frame end.

Function
REQ-011 SHALL implement an FSM with states IDLE, START, DATA, STOP.
REQ-012 SHALL assert tx_ready only in IDLE; a byte is accepted on a rising edge where tx_valid and tx_ready are both 1.
REQ-013 SHALL register tx_data (complemented if INVERT_DATA=1) into an 8-bit shift register on acceptance; later tx_data changes SHALL NOT affect the frame.
REQ-014 SHALL go IDLE->START on acceptance; tx SHALL be 0 from the cycle after acceptance (latency 1).
REQ-015 SHALL hold every bit for exactly CLKS_PER_BIT cycles, timed by a bit-period counter that is cleared on acceptance and on every bit boundary.
REQ-016 SHALL send frame order: start(0), data bits 0..7 LSB first, stop(1); frame length 10*CLKS_PER_BIT cycles.
REQ-017 SHALL count data bits with a 3-bit index; DATA->STOP after index 7 completes; the index SHALL NOT wrap into a ninth bit.
REQ-018 SHALL go STOP->IDLE at the end of the stop bit, pulse done=1 for that single final STOP cycle, and raise tx_ready on the next cycle.
REQ-019 SHALL give a minimum of one IDLE cycle (tx=1) between back-to-back frames; tx_valid held high SHALL yield continuous frames separated by exactly one idle cycle.
REQ-020 SHALL assert busy=1 in START, DATA, STOP and 0 in IDLE; busy SHALL equal ~tx_ready except during reset.
REQ-021 SHALL ignore tx_valid while not in IDLE; no queuing, no byte loss reporting.
REQ-022 SHALL register all outputs (tx, tx_ready, busy, done); no combinational path from inputs to outputs.

Reset
REQ-023 SHALL, with rst=1 at a rising edge, set state IDLE, tx=1, busy=0, done=0, tx_ready=0, and clear the counters and shift register.
REQ-024 SHALL raise tx_ready on the first edge after rst is released.
REQ-025 SHALL abort an in-progress frame if rst is asserted mid-frame, with tx=1 from the next edge and no done pulse.
REQ-026 SHALL give rst priority over a simultaneous tx_valid; the byte SHALL NOT be accepted.

Structure
REQ-027 SHALL keep the state enum, FRAME_BITS=10 and the default CLKS_PER_BIT in a shared package, adc_tx_pkg.
REQ-028 SHALL implement the bit-period counter as one sub-module, tx_baud_counter, which takes clk, rst and clear and emits a one-cycle tick at count CLKS_PER_BIT-1.
REQ-029 SHALL keep the FSM, shift register and bit index in adc_byte_tx.

Verification (CLKS_PER_BIT=4)
REQ-030 SHALL cover: INVERT_DATA=0, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; done high in cycle 40 after acceptance; busy high 40 cycles.
REQ-031 SHALL cover: INVERT_DATA=1, send 0x00 -> data bits all 1; frame = 0,1,1,1,1,1,1,1,1,1.
REQ-032 SHALL cover: tx_valid held high with bytes 0x01 then 0x80 -> two frames, with exactly 1 idle cycle (tx=1, tx_ready=1) between them.
REQ-033 SHALL cover: rst pulsed at cycle 17 of a frame -> tx=1 next cycle, busy=0, no done pulse, tx_ready=1 one cycle after rst falls.
REQ-034 SHALL cover: tx_valid pulsed during DATA with 0xFF -> ignored; the current frame completes unchanged and no second frame follows.
REQ-035 SHALL cover: rst and tx_valid high on the same edge -> no frame; tx stays 1.
